// File: rtl/mips_pkg.sv
// Shared encodings for the ID-stage branch resolution logic:
// PC-select codes, the branch controller FSM states and the stall depth
// charged for each kind of producer still in flight.
package mips_pkg;

  localparam logic [1:0] PC_SEQ    = 2'b00;
  localparam logic [1:0] PC_BRANCH = 2'b01;
  localparam logic [1:0] PC_JUMP   = 2'b10;

  // Cycles a branch must wait in ID for its operand producer.
  localparam logic [1:0] STALL_LOAD_EX  = 2'd2;
  localparam logic [1:0] STALL_ALU_EX   = 2'd1;
  localparam logic [1:0] STALL_LOAD_MEM = 2'd1;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    HOLD = 2'd2
  } br_state_e;

endpackage

// File: rtl/branch_hazard_detect.sv
// Combinational hazard depth for a branch in ID: how many cycles the
// branch operands are still unavailable, given the EX and MEM occupants.
// Register 0 is hard-wired and never creates a hazard.
module branch_hazard_detect
  import mips_pkg::*;
#(
  parameter int REG_AW = 5
) (
  input  logic [REG_AW-1:0] id_rs,
  input  logic [REG_AW-1:0] id_rt,
  input  logic              ex_reg_write,
  input  logic              ex_mem_read,
  input  logic [REG_AW-1:0] ex_rd,
  input  logic              mem_mem_read,
  input  logic [REG_AW-1:0] mem_rd,
  output logic [1:0]        depth
);

  logic ex_hit;
  logic mem_hit;

  // Match producers against the branch sources and keep the deepest wait.
  always_comb begin
    ex_hit  = (ex_rd  != '0) && ((ex_rd  == id_rs) || (ex_rd  == id_rt));
    mem_hit = (mem_rd != '0) && ((mem_rd == id_rs) || (mem_rd == id_rt));
    depth   = 2'd0;
    if (mem_mem_read && mem_hit) depth = STALL_LOAD_MEM;
    if (ex_reg_write && ex_hit)  depth = STALL_ALU_EX;
    if (ex_mem_read && ex_hit)   depth = STALL_LOAD_EX;
  end

endmodule

// File: rtl/branch_resolve_ctrl.sv
// ID-stage branch/jump resolution controller. Consumes the forwarded-operand
// equality flag, selects the next PC, computes the redirect target and holds
// a hazarded branch in ID for 1-2 cycles.
// Optional feature: define BRANCH_STATS_EN to add saturating statistics
// counters (resolved branches, taken branches, stall cycles).
module branch_resolve_ctrl
  import mips_pkg::*;
#(
  parameter int DATA_W = 32,
  parameter int REG_AW = 5,
  parameter int STAT_W = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              id_valid,
  input  logic              id_is_beq,
  input  logic              id_is_bne,
  input  logic              id_is_jump,
  input  logic [REG_AW-1:0] id_rs,
  input  logic [REG_AW-1:0] id_rt,
  input  logic [DATA_W-1:0] id_pc_plus4,
  input  logic [DATA_W-1:0] id_imm,
  input  logic [25:0]       id_jaddr,
  input  logic              cmp_equal,
  input  logic              ex_reg_write,
  input  logic              ex_mem_read,
  input  logic [REG_AW-1:0] ex_rd,
  input  logic              mem_mem_read,
  input  logic [REG_AW-1:0] mem_rd,
`ifdef BRANCH_STATS_EN
  output logic [STAT_W-1:0] stat_branches,
  output logic [STAT_W-1:0] stat_taken,
  output logic [STAT_W-1:0] stat_stall_cyc,
`endif
  output logic [1:0]        pc_src,
  output logic [DATA_W-1:0] target,
  output logic              stall,
  output logic              id_ex_bubble,
  output logic              if_id_flush
);

  br_state_e   state, state_nxt;
  logic [1:0]  cnt, cnt_nxt;
  logic [1:0]  depth;
  logic        is_branch;
  logic        is_jump;
  logic        br_taken;
  logic        resolved;
  logic signed [DATA_W-1:0] imm_s;
  logic [DATA_W-1:0] br_target;
  logic [DATA_W-1:0] j_target;

  branch_hazard_detect #(.REG_AW(REG_AW)) u_hazard (
    .id_rs        (id_rs),
    .id_rt        (id_rt),
    .ex_reg_write (ex_reg_write),
    .ex_mem_read  (ex_mem_read),
    .ex_rd        (ex_rd),
    .mem_mem_read (mem_mem_read),
    .mem_rd       (mem_rd),
    .depth        (depth)
  );

  // Instruction class decode and the two redirect addresses.
  always_comb begin
    is_branch = id_valid & (id_is_beq | id_is_bne);
    is_jump   = id_valid & id_is_jump & ~(id_is_beq | id_is_bne);
    br_taken  = id_is_beq ? cmp_equal : ~cmp_equal;
    imm_s     = $signed(id_imm);
    br_target = id_pc_plus4 + DATA_W'(imm_s <<< 2);
    j_target  = {id_pc_plus4[DATA_W-1:28], id_jaddr, 2'b00};
  end

  // Next-state and output decode; reset forces every output low.
  always_comb begin
    state_nxt    = state;
    cnt_nxt      = cnt;
    pc_src       = PC_SEQ;
    target       = '0;
    stall        = 1'b0;
    id_ex_bubble = 1'b0;
    if_id_flush  = 1'b0;
    resolved     = 1'b0;
    case (state)
      IDLE: begin
        if (is_branch) begin
          if (depth != 2'd0) begin
            stall        = 1'b1;
            id_ex_bubble = 1'b1;
            cnt_nxt      = depth - 2'd1;
            state_nxt    = (depth > 2'd1) ? WAIT : HOLD;
          end else begin
            resolved = 1'b1;
          end
        end else if (is_jump) begin
          pc_src      = PC_JUMP;
          target      = j_target;
          if_id_flush = 1'b1;
        end
      end
      WAIT: begin
        stall        = 1'b1;
        id_ex_bubble = 1'b1;
        if (cnt <= 2'd1) begin
          cnt_nxt   = 2'd0;
          state_nxt = HOLD;
        end else begin
          cnt_nxt = cnt - 2'd1;
        end
      end
      HOLD: begin
        resolved  = 1'b1;
        state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
    if (resolved && br_taken) begin
      pc_src      = PC_BRANCH;
      target      = br_target;
      if_id_flush = 1'b1;
    end
    if (rst) begin
      pc_src       = PC_SEQ;
      target       = '0;
      stall        = 1'b0;
      id_ex_bubble = 1'b0;
      if_id_flush  = 1'b0;
      resolved     = 1'b0;
    end
  end

  // FSM state and stall counter.
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      cnt   <= 2'd0;
    end else begin
      state <= state_nxt;
      cnt   <= cnt_nxt;
    end
  end

`ifdef BRANCH_STATS_EN
  logic [STAT_W-1:0] n_br, n_tk, n_st;

  function automatic logic [STAT_W-1:0] sat_inc(input logic [STAT_W-1:0] v);
    return (&v) ? v : v + 1'b1;
  endfunction

  // Saturating event counters for resolved branches, taken branches, stalls.
  always_ff @(posedge clk) begin
    if (rst) begin
      n_br <= '0;
      n_tk <= '0;
      n_st <= '0;
    end else begin
      if (resolved)             n_br <= sat_inc(n_br);
      if (resolved && br_taken) n_tk <= sat_inc(n_tk);
      if (stall)                n_st <= sat_inc(n_st);
    end
  end

  assign stat_branches  = rst ? '0 : n_br;
  assign stat_taken     = rst ? '0 : n_tk;
  assign stat_stall_cyc = rst ? '0 : n_st;
`endif

endmodule
